// File: rtl/native_app_to_axi4_master.sv
// Bridges a MIG-style native app slave port onto single-beat AXI4 master
// transactions. One command is in flight at a time; write data is staged in
// a small FIFO so it may arrive before, with or after its command.
module native_app_to_axi4_master #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_SHIFT = 0,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0,
  parameter int WDF_DEPTH  = 4
) (
  input  logic                             clock,
  input  logic                             rst,
  // native app slave side
  input  logic [ADDR_WIDTH-1:0]            app_addr,
  input  logic [2:0]                       app_cmd,
  input  logic                             app_en,
  output logic                             app_rdy,
  input  logic [DATA_WIDTH-1:0]            app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0]          app_wdf_mask,
  input  logic                             app_wdf_wren,
  input  logic                             app_wdf_end,
  output logic                             app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]            app_rd_data,
  output logic                             app_rd_data_valid,
  output logic                             app_rd_data_end,
  output logic                             init_calib_complete,
  output logic                             resp_err,
  // AXI4 write address
  output logic [ID_WIDTH-1:0]              m_awid,
  output logic [ADDR_WIDTH+ADDR_SHIFT-1:0] m_awaddr,
  output logic [7:0]                       m_awlen,
  output logic [2:0]                       m_awsize,
  output logic [1:0]                       m_awburst,
  output logic                             m_awvalid,
  input  logic                             m_awready,
  // AXI4 write data
  output logic [DATA_WIDTH-1:0]            m_wdata,
  output logic [DATA_WIDTH/8-1:0]          m_wstrb,
  output logic                             m_wlast,
  output logic                             m_wvalid,
  input  logic                             m_wready,
  // AXI4 write response
  input  logic [ID_WIDTH-1:0]              m_bid,
  input  logic [1:0]                       m_bresp,
  input  logic                             m_bvalid,
  output logic                             m_bready,
  // AXI4 read address
  output logic [ID_WIDTH-1:0]              m_arid,
  output logic [ADDR_WIDTH+ADDR_SHIFT-1:0] m_araddr,
  output logic [7:0]                       m_arlen,
  output logic [2:0]                       m_arsize,
  output logic [1:0]                       m_arburst,
  output logic                             m_arvalid,
  input  logic                             m_arready,
  // AXI4 read data
  input  logic [DATA_WIDTH-1:0]            m_rdata,
  input  logic [1:0]                       m_rresp,
  input  logic                             m_rlast,
  input  logic                             m_rvalid,
  output logic                             m_rready
);

  localparam int AXI_AW  = ADDR_WIDTH + ADDR_SHIFT;
  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int ENTRY_W = DATA_WIDTH + STRB_W;
  localparam int PTR_W   = $clog2(WDF_DEPTH);
  localparam logic [2:0] BEAT_SIZE = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t                  r_state;
  logic                    r_calib;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_awvalid;
  logic                    r_arvalid;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_rd_valid;
  logic                    r_resp_err;

  // write-data FIFO: mask is stored alongside data, pointers carry a wrap bit
  logic [ENTRY_W-1:0]      r_mem [WDF_DEPTH];
  logic [PTR_W:0]          r_wr_ptr;
  logic [PTR_W:0]          r_rd_ptr;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_wdf_rdy;
  logic                    w_app_rdy;
  logic                    w_wvalid;
  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic [ENTRY_W-1:0]      w_head;
  logic [AXI_AW-1:0]       w_axi_addr;
  logic                    w_unused;

  // these inputs carry no information for single-beat transfers
  assign w_unused = ^{app_wdf_end, m_bid, m_rlast};

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  // gating with calibration keeps the data port closed while in reset
  assign w_wdf_rdy = !w_full && r_calib;
  assign w_push    = app_wdf_wren && w_wdf_rdy;
  assign w_head    = r_mem[r_rd_ptr[PTR_W-1:0]];

  assign w_app_rdy = (r_state == IDLE) && r_calib;
  assign w_wvalid  = (r_state == WR_REQ) && !w_empty && !r_w_done;
  assign w_pop     = w_wvalid && m_wready;
  assign w_aw_hs   = r_awvalid && m_awready;
  assign w_w_hs    = w_pop;
  assign w_axi_addr = AXI_AW'(r_addr) << ADDR_SHIFT;

  // calibration flag: usable from the first clock after reset release
  always_ff @(posedge clock or posedge rst) begin
    if (rst) r_calib <= 1'b0;
    else     r_calib <= 1'b1;
  end

  // FIFO storage, no reset needed since the pointers gate visibility
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= {app_wdf_mask, app_wdf_data};
  end

  // FIFO pointers; reset flushes any staged beats
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // command FSM with registered AXI valids, read data and sticky error
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_awvalid  <= 1'b0;
      r_arvalid  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_resp_err <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (app_en && w_app_rdy) begin
            r_addr    <= app_addr;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (app_cmd == 3'd0) begin
              r_state   <= WR_REQ;
              r_awvalid <= 1'b1;
            end else if (app_cmd == 3'd1) begin
              r_state   <= RD_REQ;
              r_arvalid <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) r_w_done <= 1'b1;
          // both halves may finish in the same cycle
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) r_state <= WR_RESP;
        end
        WR_RESP: begin
          if (m_bvalid) begin
            r_state <= IDLE;
            if (m_bresp != 2'b00) r_resp_err <= 1'b1;
          end
        end
        RD_REQ: begin
          if (m_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          // single beat: completion does not wait on rlast
          if (m_rvalid) begin
            r_rd_data  <= m_rdata;
            r_rd_valid <= 1'b1;
            r_state    <= IDLE;
            if (m_rresp != 2'b00) r_resp_err <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign app_rdy             = w_app_rdy;
  assign app_wdf_rdy         = w_wdf_rdy;
  assign app_rd_data         = r_rd_data;
  assign app_rd_data_valid   = r_rd_valid;
  assign app_rd_data_end     = r_rd_valid;
  assign init_calib_complete = r_calib;
  assign resp_err            = r_resp_err;

  assign m_awid    = ID_WIDTH'(AXI_ID);
  assign m_awaddr  = w_axi_addr;
  assign m_awlen   = 8'd0;
  assign m_awsize  = BEAT_SIZE;
  assign m_awburst = 2'b01;
  assign m_awvalid = r_awvalid;

  assign m_wdata   = w_head[DATA_WIDTH-1:0];
  assign m_wstrb   = ~w_head[ENTRY_W-1:DATA_WIDTH];
  assign m_wlast   = 1'b1;
  assign m_wvalid  = w_wvalid;

  assign m_bready  = (r_state == WR_RESP);

  assign m_arid    = ID_WIDTH'(AXI_ID);
  assign m_araddr  = w_axi_addr;
  assign m_arlen   = 8'd0;
  assign m_arsize  = BEAT_SIZE;
  assign m_arburst = 2'b01;
  assign m_arvalid = r_arvalid;

  assign m_rready  = (r_state == RD_DATA);

endmodule

// File: doc/native_app_to_axi4_master.md
Name: native_app_to_axi4_master

Overview:
- Presents a Xilinx-MIG-style native "app" slave interface (app_cmd/app_en/app_wdf_*/app_rd_data*) to a native user.
- Converts each accepted app command into a single-beat AXI4 master transaction.
- Lets native-interface logic, DDR test masters and native models drive any AXI4 slave in the fabric, including our AXI4-to-native DDR bridge for loopback checking.
- One command is outstanding at a time; write data is buffered in a small FIFO.

Parameters:
- ADDR_WIDTH, 27, app_addr width.
- DATA_WIDTH, 256, data width on both sides (power of 2, >= 8).
- ADDR_SHIFT, 0, AXI byte address = app_addr << ADDR_SHIFT.
- ID_WIDTH, 4, AXI ID width.
- AXI_ID, 0, constant value driven on awid/arid.
- WDF_DEPTH, 4, write-data FIFO depth (power of 2, >= 2).

Ports:
- clock  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- app_addr  in  ADDR_WIDTH  command address.
- app_cmd  in  3  0=write, 1=read, other=no-op.
- app_en  in  1  command valid.
- app_rdy  out  1  command ready.
- app_wdf_data  in  DATA_WIDTH  write data.
- app_wdf_mask  in  DATA_WIDTH/8  byte mask; 1 = byte not written.
- app_wdf_wren  in  1  write-data valid.
- app_wdf_end  in  1  ignored (always single beat).
- app_wdf_rdy  out  1  write-data ready.
- app_rd_data  out  DATA_WIDTH  read data.
- app_rd_data_valid  out  1  read data valid.
- app_rd_data_end  out  1  last read beat.
- init_calib_complete  out  1  interface usable.
- resp_err  out  1  sticky: bresp or rresp was non-OKAY.
- m_awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_WIDTH/ADDR_WIDTH+ADDR_SHIFT/8/3/2/1  AW channel.
- m_awready  in  1.
- m_wdata/wstrb/wlast/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1/1  W channel.
- m_wready  in  1.
- m_bid/bresp/bvalid  in  ID_WIDTH/2/1.
- m_bready  out  1.
- m_arid/araddr/arlen/arsize/arburst/arvalid  out  same widths as AW.
- m_arready  in  1.
- m_rdata/rresp/rlast/rvalid  in  DATA_WIDTH/2/1/1.
- m_rready  out  1.

Behaviour:
- Reset values: all valid/ready/flag outputs 0, app_rd_data 0, address registers 0. Write FIFO is emptied and the FSM goes to IDLE.
- init_calib_complete is registered 1 from the first clock after rst deasserts and stays 1 until reset.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA.
- app_rdy = (state==IDLE) && init_calib_complete. A command is accepted on app_en && app_rdy.
- On acceptance, app_addr is latched and the next state is:
  - app_cmd=0: WR_REQ.
  - app_cmd=1: RD_REQ.
  - other: IDLE (command discarded, no AXI activity).
- Constant AXI fields: awlen=arlen=0, awsize=arsize=log2(DATA_WIDTH/8), awburst=arburst=2'b01, awid=arid=AXI_ID, wlast=1.
- Address: awaddr/araddr = latched app_addr << ADDR_SHIFT.
- Write-data FIFO:
  - Push on app_wdf_wren && app_wdf_rdy; app_wdf_rdy = !full.
  - Push/pop in the same cycle is legal when not full. When full, no push-through.
  - Data may arrive before, with, or after its command, in command order.
- WR_REQ:
  - awvalid is registered high in the first WR_REQ cycle (command accept cycle N, awvalid at N+1) and held until m_awready.
  - wvalid = FIFO non-empty && !w_done. wdata = FIFO head; wstrb = ~mask at FIFO head. Pop on wvalid && m_wready.
  - aw_done and w_done are tracked independently.
  - Move to WR_RESP when both are done, including both completing in the same cycle.
- WR_RESP: bready=1. On bvalid, go to IDLE and set resp_err if bresp != 0.
- RD_REQ: arvalid held until m_arready, then go to RD_DATA.
- RD_DATA:
  - rready=1. On rvalid, go to IDLE; completion does not depend on rlast.
  - app_rd_data/rresp are registered; app_rd_data_valid and app_rd_data_end pulse 1 in the next cycle (one-cycle latency).
  - resp_err is set if rresp != 0.
- No AXI valid drops before its handshake completes.
- Reset mid-transaction aborts immediately: the outstanding AXI transaction is abandoned and the FIFO is flushed.

Test Plan:
- Write with data 2 cycles before command: app_addr=0x10, ADDR_SHIFT=5, data=0xA5.., mask=0 -> awaddr=0x200, wdata=0xA5.., wstrb=all 1s. bvalid -> app_rdy returns 1 the cycle after the b handshake.
- Read: app_addr=0x3, slave returns rdata=0x1234 with rlast=1 -> app_rd_data=0x1234, app_rd_data_valid=app_rd_data_end=1 for exactly one cycle, one cycle after the r handshake.
- Back-pressure: hold m_awready=0 for 5 cycles while m_wready=1 -> wvalid drops after 1 beat, awvalid stays 1. awready then fires -> single b handshake, FIFO empty.
- FIFO full: push 4 beats with no command -> app_wdf_rdy=0 after the 4th. Issue 4 writes -> 4 AXI writes with the data in order; app_wdf_rdy returns 1 after the first pop.
- Errors and no-ops: bresp=2'b10 -> resp_err=1 and remains 1. app_cmd=3'b111 accepted -> no AW/AR activity, app_rdy=1 the next cycle.
- Reset during WR_REQ with awvalid=1 -> awvalid=0 and app_wdf_rdy=0 during reset. init_calib_complete=1 one cycle after release, FIFO empty.
